// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer-mode codes, receive FSM states, default frame width.
package spi_pkg;

    localparam logic [1:0] DTF_NONE = 2'b00;
    localparam logic [1:0] DTF_S2M  = 2'b01;
    localparam logic [1:0] DTF_M2S  = 2'b10;
    localparam logic [1:0] DTF_FDX  = 2'b11;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PUSH   = 2'd2
    } rx_state_t;

    // True when the transfer mode carries master-to-slave data.
    function automatic logic dtf_rx(input logic [1:0] dtf);
        logic rx;
        case (dtf)
            DTF_M2S, DTF_FDX:  rx = 1'b1;
            DTF_NONE, DTF_S2M: rx = 1'b0;
            default:           rx = 1'b0;
        endcase
        return rx;
    endfunction

endpackage

// File: rtl/spi_slave_rx_buffer_fifo.sv
// spi_rx_fifo: first-word-fall-through byte queue.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (push), rd_en (pop request),
//        rd_data (head, zero while empty), full, empty, level (occupancy 0..DEPTH).
module spi_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == LVL_W'(0));
    assign level = count;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Head is presented combinationally; forced to zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_slave_rx_buffer.sv
// spi_slave_rx_buffer: oversampling SPI slave receiver feeding a FWFT byte FIFO.
// Ports: clk, rst (sync, active-high); sclk, mosi, ssb (async SPI pins, ssb high = selected);
//        dtf (transfer mode, quasi-static); rd_data/rd_valid/rd_ready (consumer handshake);
//        level (FIFO occupancy); overflow (sticky drop flag); frame_err (pulse on aborted frame).
// Build option: define SPI_RX_MSB_FIRST_EN to place the first received bit in the MSB.
module spi_slave_rx_buffer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         mosi,
    input  logic                         ssb,
    input  logic [1:0]                   dtf,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         frame_err
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ssb_sync;
    logic                   sclk_d;
    logic                   rise_q;
    logic                   mosi_q;
    logic                   ssb_q;

    rx_state_t              state,     state_n;
    logic [CNT_W-1:0]       bit_cnt,   bit_cnt_n;
    logic [DATA_W-1:0]      shift_reg, shift_n;
    logic                   overflow_n;
    logic                   frame_err_n;
    logic                   wr_en_c;
    logic [CNT_W-1:0]       bit_idx_c;
    logic                   rx_en_c;
    logic                   pop_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Identical sync chains, then one aligned stage holding the sclk rise pulse with its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ssb_sync  <= '0;
            sclk_d    <= 1'b0;
            rise_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ssb_q     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ssb_sync  <= {ssb_sync[SYNC_STAGES-2:0],  ssb};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            rise_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
            ssb_q     <= ssb_sync[SYNC_STAGES-1];
        end
    end

    assign rx_en_c = ssb_q & dtf_rx(dtf);
    assign pop_c   = rd_valid & rd_ready;

`ifdef SPI_RX_MSB_FIRST_EN
    assign bit_idx_c = CNT_W'(DATA_W-1) - bit_cnt;
`else
    assign bit_idx_c = bit_cnt;
`endif

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            overflow  <= overflow_n;
            frame_err <= frame_err_n;
        end
    end

    // Receive FSM next-state and push control.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        overflow_n  = overflow;
        frame_err_n = 1'b0;
        wr_en_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                bit_cnt_n = '0;
                if (rx_en_c) state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!rx_en_c) begin
                    // Losing select only counts as an error once a frame has started.
                    frame_err_n = (bit_cnt != '0);
                    bit_cnt_n   = '0;
                    state_n     = ST_IDLE;
                end else if (rise_q) begin
                    shift_n[bit_idx_c] = mosi_q;
                    if (bit_cnt == CNT_W'(DATA_W-1)) begin
                        bit_cnt_n = '0;
                        state_n   = ST_PUSH;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PUSH: begin
                wr_en_c = 1'b1;
                if (fifo_full && !pop_c) overflow_n = 1'b1;
                state_n = rx_en_c ? ST_ACTIVE : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_data (shift_reg),
        .rd_en   (pop_c),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign rd_valid = ~fifo_empty;

endmodule

// File: tb/tb_spi_slave_rx_buffer.sv
// Self-checking bench for spi_slave_rx_buffer against a queue-based transaction model.
module tb_spi_slave_rx_buffer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned HALF   = 4;
    localparam int unsigned LAT    = SYNC + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       ssb;
    logic [1:0] dtf;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] level;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;

    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    spi_slave_rx_buffer #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .ssb       (ssb),
        .dtf       (dtf),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    // Counts clk cycles during which frame_err is high.
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte the receiver should store when the master shifts d out LSB first.
    function automatic logic [7:0] expect_byte(input logic [7:0] d);
        logic [7:0] r;
`ifdef SPI_RX_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = d[i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0; mosi = d[i]; tick(HALF);
            sclk = 1'b1; tick(HALF);
        end
        sclk = 1'b0;
        tick(HALF);
    endtask

    // Full byte; optionally pops the head exactly in the push cycle.
    task automatic send_byte(input logic [7:0] d, input bit pop_in_push);
        bit was_empty;
        int lat;
        was_empty = (mq.size() == 0);
        lat = 0;
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b0; mosi = d[i]; tick(HALF);
            sclk = 1'b1; tick(HALF);
        end
        sclk = 1'b0; mosi = d[7]; tick(HALF);
        sclk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (lat == 0 && rd_valid === 1'b1) lat = k;
            if (pop_in_push) begin
                if (k == int'(LAT) - 1) begin
                    check("push_pop_head", rd_data, mq[0]);
                    rd_ready = 1'b1;
                end
                if (k == int'(LAT)) begin
                    rd_ready = 1'b0;
                    void'(mq.pop_front());
                end
            end
        end
        sclk = 1'b0;
        tick(HALF);
        if (was_empty) check("latency", lat, LAT);
        if (mq.size() < DEPTH) mq.push_back(expect_byte(d));
        else m_ovf = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        int w;
        logic [7:0] exp;
        w = 0;
        while (rd_valid !== 1'b1 && w < 20) begin
            tick(1);
            w++;
        end
        check({tag, "_valid"}, rd_valid, 1);
        if (rd_valid === 1'b1 && mq.size() != 0) begin
            exp = mq.pop_front();
            check({tag, "_data"}, rd_data, exp);
            rd_ready = 1'b1;
            tick(1);
            rd_ready = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, level, mq.size());
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_valid"}, rd_valid, (mq.size() != 0));
        if (mq.size() != 0) check({tag, "_head"}, rd_data, mq[0]);
    endtask

    task automatic abort_frame(input int n);
        int f0;
        f0 = fe_cnt;
        send_bits(8'($urandom), n);
        ssb = 1'b0;
        tick(8);
        check("abort_fe_pulse", fe_cnt - f0, 1);
        ssb = 1'b1;
        tick(4);
    endtask

    initial begin
        int f0;
        int choice;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ssb = 1'b0; dtf = 2'b10; rd_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_fe", frame_err, 0);
        ssb = 1'b1;
        tick(4);

        // Single byte
        send_byte(8'h75, 1'b0);
        check("t1_data", rd_data, expect_byte(8'h75));
        check("t1_level", level, 1);
        pop_check("t1_pop");
        check_state("t1_end");

        // Non-receiving transfer modes
        f0 = fe_cnt;
        dtf = 2'b01; tick(6);
        send_bits(8'hFF, 8);
        dtf = 2'b00; tick(2);
        send_bits(8'h0F, 8);
        check("t4_level", level, 0);
        check("t4_valid", rd_valid, 0);
        check("t4_fe", fe_cnt - f0, 0);
        dtf = 2'b10; tick(4);

        // Aborted frame between two good bytes
        send_byte(8'h11, 1'b0);
        abort_frame(3);
        check("t3_level", level, 1);
        send_byte(8'hA5, 1'b0);
        pop_check("t3_pop0");
        pop_check("t3_pop1");

        // Full FIFO with a pop in the push cycle
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        check("t5_full", level, 8);
        send_byte(8'h3C, 1'b1);
        check("t5_level", level, 8);
        check("t5_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) pop_check("t5_drain");
        check("t5_last", rd_data, expect_byte(8'h3C));
        pop_check("t5_drain_last");

        // Overflow on the ninth byte
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 7) check("t2_ovf_before", overflow, 0);
        end
        check("t2_level", level, 8);
        check("t2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) pop_check("t2_drain");
        check_state("t2_end");

        // Reset mid-byte
        send_byte(8'h99, 1'b0);
        send_bits(8'h1F, 5);
        rst = 1'b1;
        tick(1);
        check("t6_valid", rd_valid, 0);
        check("t6_data", rd_data, 0);
        check("t6_level", level, 0);
        check("t6_ovf", overflow, 0);
        check("t6_fe", frame_err, 0);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        tick(4);
        send_byte(8'h52, 1'b0);
        pop_check("t6_pop");

        // Random mix of bytes, pops and aborts
        for (int it = 0; it < 40; it++) begin
            choice = int'($urandom_range(0, 9));
            if (choice <= 5) send_byte(8'($urandom), 1'b0);
            else if (choice <= 8) begin
                if (mq.size() != 0) pop_check("rnd_pop");
            end else abort_frame(int'($urandom_range(1, 7)));
            check_state("rnd");
        end
        while (mq.size() != 0) pop_check("rnd_drain");
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
